// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Memory-stage access controller. Takes the latched EX/MEM
//            address, store data and memory control bits. Runs a
//            request/acknowledge handshake with a variable-latency data
//            memory and stalls the front of the pipeline until the access
//            retires. Presents load data and completion status to MEM/WB.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT      : REQ cycles allowed before the access is abandoned (1..255)
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous, active-low reset
//   valid_in     : EX/MEM holds a live instruction
//   addr_in      : ALU result, used as memory address
//   wdata_in     : store data
//   mem_write_in : instruction is a store
//   mem_read_in  : instruction is a load
//   halt_in      : instruction is halt
//   stall        : hold EX/MEM and upstream (EX/MEM en = ~stall)
//   rdata_out    : registered load data
//   done_out     : one-cycle pulse, access retired
//   err_out      : sticky error (timeout / misalignment)
//   halted_out   : sticky, halt retired
//   mem_req/mem_we/mem_addr/mem_wdata : request to data memory
//   mem_ack/mem_rdata                  : response from data memory
// Build option
//   MEM_ALIGN_CHECK_EN : when defined, odd addresses are rejected with
//                        err_out and never reach the memory.
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [15:0] addr_in,
    input  logic [15:0] wdata_in,
    input  logic        mem_write_in,
    input  logic        mem_read_in,
    input  logic        halt_in,
    output logic        stall,
    output logic [15:0] rdata_out,
    output logic        done_out,
    output logic        err_out,
    output logic        halted_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Wait counter compares against the last permitted REQ cycle index.
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [7:0]  r_wait;
    logic [15:0] r_rdata;
    logic        r_err;
    logic        r_halted;
    logic        r_we;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;

    logic        w_pending;
    logic        w_misaligned;
    logic        w_timeout;
    logic        w_stall;

    assign w_pending = valid_in & (mem_write_in | mem_read_in) & ~r_halted;
    assign w_timeout = (r_wait == c_TIMEOUT_LAST);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misaligned = addr_in[0];
`else
    assign w_misaligned = 1'b0;
`endif

    // Next-state and stall decode.
    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_pending) begin
                    w_stall      = 1'b1;
                    w_next_state = w_misaligned ? c_DONE : c_REQ;
                end
            end
            c_REQ: begin
                w_stall = 1'b1;
                if (mem_ack || w_timeout) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE: begin
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath and sticky status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait   <= 8'd0;
            r_rdata  <= 16'h0000;
            r_err    <= 1'b0;
            r_halted <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 16'h0000;
            r_wdata  <= 16'h0000;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (valid_in && halt_in && !r_halted) begin
                        r_halted <= 1'b1;
                    end
                    if (w_pending) begin
                        if (w_misaligned) begin
                            // Rejected without touching memory or load data.
                            r_err <= 1'b1;
                        end else begin
                            r_addr  <= addr_in;
                            r_wdata <= wdata_in;
                            r_we    <= mem_write_in;
                            r_wait  <= 8'd0;
                        end
                    end
                end
                c_REQ: begin
                    r_wait <= r_wait + 8'd1;
                    if (mem_ack) begin
                        if (!r_we) begin
                            r_rdata <= mem_rdata;
                        end
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= 16'h0000;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Gating with rst lets stall fall as soon as reset asserts, even while an
    // access is still presented on the inputs.
    assign stall      = rst & w_stall;
    assign mem_req    = (r_state == c_REQ);
    assign done_out   = (r_state == c_DONE);
    assign rdata_out  = r_rdata;
    assign err_out    = r_err;
    assign halted_out = r_halted;
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Directed self-checking bench for mem_access_ctrl (TIMEOUT=5).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [15:0] addr_in;
    logic [15:0] wdata_in;
    logic        mem_write_in;
    logic        mem_read_in;
    logic        halt_in;
    logic        stall;
    logic [15:0] rdata_out;
    logic        done_out;
    logic        err_out;
    logic        halted_out;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_ctrl #(
        .TIMEOUT(5)
    ) dut (
        .clk         (clk),
        .rst         (rst_n),
        .valid_in    (valid_in),
        .addr_in     (addr_in),
        .wdata_in    (wdata_in),
        .mem_write_in(mem_write_in),
        .mem_read_in (mem_read_in),
        .halt_in     (halt_in),
        .stall       (stall),
        .rdata_out   (rdata_out),
        .done_out    (done_out),
        .err_out     (err_out),
        .halted_out  (halted_out),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; inputs and checks happen mid-cycle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        valid_in     = 1'b0;
        addr_in      = 16'h0000;
        wdata_in     = 16'h0000;
        mem_write_in = 1'b0;
        mem_read_in  = 1'b0;
        halt_in      = 1'b0;
        mem_ack      = 1'b0;
        mem_rdata    = 16'h0000;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_stall"},  {15'd0, stall},      16'h0);
        check({tag, "_done"},   {15'd0, done_out},   16'h0);
        check({tag, "_err"},    {15'd0, err_out},    16'h0);
        check({tag, "_halted"}, {15'd0, halted_out}, 16'h0);
        check({tag, "_req"},    {15'd0, mem_req},    16'h0);
        check({tag, "_we"},     {15'd0, mem_we},     16'h0);
        check({tag, "_rdata"},  rdata_out,           16'h0000);
        check({tag, "_addr"},   mem_addr,            16'h0000);
        check({tag, "_wdata"},  mem_wdata,           16'h0000);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_values("rst");
        rst_n = 1'b1;
        tick();

        // ---- Load at 0x0010, ack on first REQ cycle ----
        valid_in = 1'b1; mem_read_in = 1'b1; addr_in = 16'h0010;
        #1;
        check("ld_idle_stall", {15'd0, stall},   16'h1);
        check("ld_idle_req",   {15'd0, mem_req}, 16'h0);
        tick();
        check("ld_req_req",   {15'd0, mem_req}, 16'h1);
        check("ld_req_stall", {15'd0, stall},   16'h1);
        check("ld_req_we",    {15'd0, mem_we},  16'h0);
        check("ld_req_addr",  mem_addr,         16'h0010);
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        check("ld_done",       {15'd0, done_out}, 16'h1);
        check("ld_done_stall", {15'd0, stall},    16'h0);
        check("ld_done_req",   {15'd0, mem_req},  16'h0);
        check("ld_rdata",      rdata_out,         16'hBEEF);
        valid_in = 1'b0; mem_read_in = 1'b0;
        tick();
        check("ld_after_done", {15'd0, done_out}, 16'h0);

        // ---- Store at 0x0020, ack on fourth REQ cycle ----
        valid_in = 1'b1; mem_write_in = 1'b1; addr_in = 16'h0020; wdata_in = 16'h1234;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("st_req",   {15'd0, mem_req}, 16'h1);
            check("st_we",    {15'd0, mem_we},  16'h1);
            check("st_wdata", mem_wdata,        16'h1234);
            check("st_stall", {15'd0, stall},   16'h1);
            if (i == 3) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        check("st_done",  {15'd0, done_out}, 16'h1);
        check("st_rdata", rdata_out,         16'hBEEF);
        valid_in = 1'b0; mem_write_in = 1'b0;
        tick();

        // ---- Odd address load at 0x0011 ----
        valid_in = 1'b1; mem_read_in = 1'b1; addr_in = 16'h0011;
        #1;
        check("odd_idle_stall", {15'd0, stall}, 16'h1);
        tick();
`ifdef MEM_ALIGN_CHECK_EN
        check("odd_req",   {15'd0, mem_req},  16'h0);
        check("odd_done",  {15'd0, done_out}, 16'h1);
        check("odd_err",   {15'd0, err_out},  16'h1);
        check("odd_rdata", rdata_out,         16'hBEEF);
`else
        check("odd_req",  {15'd0, mem_req}, 16'h1);
        check("odd_addr", mem_addr,         16'h0011);
        mem_ack = 1'b1; mem_rdata = 16'h5A5A;
        tick();
        mem_ack = 1'b0;
        check("odd_done",  {15'd0, done_out}, 16'h1);
        check("odd_err",   {15'd0, err_out},  16'h0);
        check("odd_rdata", rdata_out,         16'h5A5A);
`endif
        valid_in = 1'b0; mem_read_in = 1'b0;
        tick();

        // ---- Load at 0x0030 with no ack: times out after 5 REQ cycles ----
        valid_in = 1'b1; mem_read_in = 1'b1; addr_in = 16'h0030;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("to_req",  {15'd0, mem_req},  16'h1);
            check("to_done", {15'd0, done_out}, 16'h0);
            tick();
        end
        check("to_done_pulse", {15'd0, done_out}, 16'h1);
        check("to_req_drop",   {15'd0, mem_req},  16'h0);
        check("to_err",        {15'd0, err_out},  16'h1);
        check("to_rdata",      rdata_out,         16'h0000);
        valid_in = 1'b0; mem_read_in = 1'b0;
        tick();

        // Following store still completes normally.
        valid_in = 1'b1; mem_write_in = 1'b1; addr_in = 16'h0040; wdata_in = 16'h00AA;
        tick();
        check("st2_req",   {15'd0, mem_req}, 16'h1);
        check("st2_addr",  mem_addr,         16'h0040);
        check("st2_wdata", mem_wdata,        16'h00AA);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("st2_done", {15'd0, done_out}, 16'h1);
        check("st2_err",  {15'd0, err_out},  16'h1);
        valid_in = 1'b0; mem_write_in = 1'b0;
        tick();

        // ---- Reset asserted during REQ ----
        valid_in = 1'b1; mem_read_in = 1'b1; addr_in = 16'h0050;
        tick();
        check("mid_req_before", {15'd0, mem_req}, 16'h1);
        rst_n = 1'b0;
        #1;
        check("mid_req_drop",   {15'd0, mem_req}, 16'h0);
        check("mid_stall_drop", {15'd0, stall},   16'h0);
        valid_in = 1'b0; mem_read_in = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_reset_values("mid_rst");

        // ---- Halt then a load: no access issued ----
        valid_in = 1'b1; halt_in = 1'b1;
        #1;
        check("halt_stall", {15'd0, stall}, 16'h0);
        tick();
        halt_in = 1'b0;
        check("halted", {15'd0, halted_out}, 16'h1);
        mem_read_in = 1'b1; addr_in = 16'h0060;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hl_stall", {15'd0, stall},    16'h0);
            check("hl_req",   {15'd0, mem_req},  16'h0);
            check("hl_done",  {15'd0, done_out}, 16'h0);
            tick();
        end
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
